instr_fetch_8085: RTL and testbench
===================================

# instr_fetch_8085

Instruction fetch and pre-decode stage directly upstream of the 8085 single-cycle execute datapath. It streams bytes from a synchronous program ROM and uses the opcode to decide each instruction's length (1, 2 or 3 bytes). It assembles whole instructions and queues them in a small FIFO, which presents one complete instruction at a time to the execute stage over a valid/ready handshake. It also redirects fetch on taken branches and stops fetching after HLT.

## Interface
Parameters:
- DEPTH, 2, instruction FIFO entries (≥2)
- RESET_PC, 16'h0000, fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_rd  out  1  read strobe to program ROM
- mem_addr  out  16  byte address for the read
- mem_data  in  8  ROM data, valid the cycle after mem_rd
- branch_valid  in  1  one-cycle redirect request from execute
- branch_target  in  16  redirect address
- instr_valid  out  1  FIFO head holds a complete instruction
- instr_ready  in  1  execute accepts the head
- instr_opcode  out  8  byte 1
- instr_b2  out  8  byte 2 (low data/addr); 0 if unused
- instr_b3  out  8  byte 3 (high addr); 0 if unused
- instr_len  out  2  1, 2 or 3
- instr_pc  out  16  address of the opcode byte

## Operation
- fetch_pc register: a read is issued when mem_rd=1 and mem_addr=fetch_pc. fetch_pc increments by 1 for each issue and wraps FFFF→0000.
- inflight flag = a read was issued last cycle and not squashed. When set, mem_data is captured at this cycle's closing edge.
- Issue rule: mem_rd = !halted && !branch_valid && (count − pop + inflight < DEPTH), where pop = instr_valid && instr_ready. mem_rd and mem_addr are combinational from registered state.
- Assembler FSM, advanced only by captured bytes:
  - ST_OP: latch opcode and instr_pc; len from the length table; len 1 → push, stay ST_OP; otherwise → ST_B2.
  - ST_B2: latch b2; len 2 → push → ST_OP; len 3 → ST_B3.
  - ST_B3: latch b3, push → ST_OP.
- Length table:
  - len 3: 01,11,21,31,22,2A,32,3A,C3,CD, Jcc (11ccc010), Ccc (11ccc100)
  - len 2: 06,0E,16,1E,26,2E,36,3E,C6,CE,D6,DE,E6,EE,F6,FE,D3,DB
  - all other opcodes are len 1
- HLT (76) push sets halted. While halted, no reads are issued; only a branch clears halted.
- FIFO: push and pop in the same cycle are both honoured. The issue rule guarantees no push is ever made into a full FIFO.
- Branch (branch_valid=1) wins over every other event that cycle:
  - FIFO is emptied; any pop that cycle is ignored.
  - FSM → ST_OP; any partial instruction is dropped.
  - inflight is squashed; its byte arriving next cycle is discarded.
  - fetch_pc = branch_target; halted cleared.
  - No read is issued in the branch cycle.
- Reset values: fetch_pc=RESET_PC; FSM=ST_OP; count=0; inflight=0; halted=0; mem_rd=0 during reset; instr_valid=0; all instr_* fields = 0.
- Reset asserted mid-instruction discards all state immediately (asynchronous).

## Timing
- First read issues in the first cycle after rst_n deasserts (cycle 0); its byte is captured at the end of cycle 1.
- Cycle in which instr_valid first rises: 1-byte instruction → cycle 2; 2-byte → cycle 3; 3-byte → cycle 4.
- Sustained throughput with instr_ready=1: one byte per cycle, so a stream of 1-byte opcodes yields one instruction per cycle.
- After a branch in cycle B: target read issues in B+1; first instruction at target valid no earlier than B+3.
- instr_valid and the head fields stay stable while instr_ready=0 (no branch).

## Structure
- Package pkg_8085: FSM state enum, opcode constants (HLT=8'h76 etc.) and a length function.
- Sub-module opcode_len_8085: combinational, opcode[7:0] → len[1:0]; shared with the decoder.
- FIFO may stay inline as a circular buffer with a count register.

## Test plan
- ROM 0000: 3E 42 76 (MVI A,42h; HLT), ready=1 → pc0000 len2 b2=42 valid at cycle 3; pc0002 len1 76 at cycle 4; then mem_rd stays 0.
- ROM 0000: C3 34 12 → one instruction: len3, b2=34, b3=12, pc0000, valid at cycle 4.
- ROM of 00 bytes (NOPs) with ready=0 → fetching stops with exactly DEPTH entries and instr_pc=0000 held. Raising ready → pcs 0000,0001,… in order, none skipped or duplicated.
- branch_valid while mid-fetch in ST_B3 (target 0100, ROM 0100: 76) → partial instruction dropped, squashed byte discarded, next instr pc0100 opcode 76; FIFO never shows pre-branch data.
- branch_valid and pop in the same cycle with count=2 → count=0 next cycle; no entry at the old addresses appears afterwards.
- rst_n pulsed low mid-instruction at fetch_pc=0005 → instr_valid=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_8085_pkg.sv
// Shared types for the 8085 fetch/pre-decode stage: assembler states,
// queued instruction record, opcode constants and the length decode.
package pkg_8085;

    typedef enum logic [1:0] {
        ST_OP = 2'd0,
        ST_B2 = 2'd1,
        ST_B3 = 2'd2
    } asm_st_e;

    localparam logic [7:0] OP_HLT  = 8'h76;
    localparam logic [7:0] OP_JMP  = 8'hC3;
    localparam logic [7:0] OP_CALL = 8'hCD;
    localparam logic [7:0] OP_OUT  = 8'hD3;
    localparam logic [7:0] OP_IN   = 8'hDB;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [1:0]  len;
        logic [15:0] pc;
    } instr_t;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        // MVI r,d8 and the immediate ALU group share the xxx110 low field
        if (op[7:6] == 2'b00 && op[2:0] == 3'b110) len = 2'd2;
        if (op[7:6] == 2'b11 && op[2:0] == 3'b110) len = 2'd2;
        if (op == OP_OUT || op == OP_IN) len = 2'd2;
        // LXI rp; SHLD/LHLD/STA/LDA; JMP/CALL; conditional jumps and calls
        if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) len = 2'd3;
        if (op[7:5] == 3'b001 && op[2:0] == 3'b010) len = 2'd3;
        if (op == OP_JMP || op == OP_CALL) len = 2'd3;
        if (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) len = 2'd3;
        return len;
    endfunction

endpackage

// File: rtl/instr_fetch_8085_opcode_len.sv
// Combinational opcode length decode, shared with the execute-side decoder.
module opcode_len_8085
    import pkg_8085::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = op_len(opcode);

endmodule

// File: rtl/instr_fetch_8085.sv
// Fetch and pre-decode: streams ROM bytes, assembles 1-3 byte instructions
// and queues them for execute. Handshake: a head entry transfers on any clock
// edge where instr_valid and instr_ready are both high; it holds otherwise.
module instr_fetch_8085
    import pkg_8085::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_b2,
    output logic [7:0]  instr_b3,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic          halted_q,   halted_d;
    asm_st_e       st_q,       st_d;
    logic [7:0]    op_q,       op_d;
    logic [7:0]    b2_q,       b2_d;
    logic [1:0]    len_q,      len_d;
    logic [15:0]   pc_q,       pc_d;
    instr_t        fifo_q [DEPTH];
    instr_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;

    logic          pop;
    logic          push;
    instr_t        push_entry;
    instr_t        head;
    logic [1:0]    byte_len;
    logic [CW:0]   occupancy;
    logic [15:0]   cap_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    opcode_len_8085 u_len (
        .opcode (mem_data),
        .len    (byte_len)
    );

    assign head        = fifo_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    // Occupancy counts the byte still in flight so a push can never overflow.
    assign occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign mem_rd    = rst_n && !halted_q && !branch_valid && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr  = fetch_pc_q;
    // The in-flight byte was read from the address just before fetch_pc.
    assign cap_pc    = fetch_pc_q - 16'd1;

    assign instr_opcode = instr_valid ? head.op  : '0;
    assign instr_b2     = instr_valid ? head.b2  : '0;
    assign instr_b3     = instr_valid ? head.b3  : '0;
    assign instr_len    = instr_valid ? head.len : '0;
    assign instr_pc     = instr_valid ? head.pc  : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = mem_rd;
        halted_d   = halted_q;
        st_d       = st_q;
        op_d       = op_q;
        b2_d       = b2_q;
        len_d      = len_q;
        pc_d       = pc_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push       = 1'b0;
        push_entry = '0;

        if (inflight_q) begin
            case (st_q)
                ST_OP: begin
                    op_d  = mem_data;
                    pc_d  = cap_pc;
                    len_d = byte_len;
                    b2_d  = '0;
                    if (byte_len == 2'd1) begin
                        push       = 1'b1;
                        push_entry = '{op: mem_data, b2: 8'h00, b3: 8'h00, len: 2'd1, pc: cap_pc};
                    end else begin
                        st_d = ST_B2;
                    end
                end
                ST_B2: begin
                    b2_d = mem_data;
                    if (len_q == 2'd2) begin
                        push       = 1'b1;
                        push_entry = '{op: op_q, b2: mem_data, b3: 8'h00, len: 2'd2, pc: pc_q};
                        st_d       = ST_OP;
                    end else begin
                        st_d = ST_B3;
                    end
                end
                ST_B3: begin
                    push       = 1'b1;
                    push_entry = '{op: op_q, b2: b2_q, b3: mem_data, len: 2'd3, pc: pc_q};
                    st_d       = ST_OP;
                end
                default: st_d = ST_OP;
            endcase
        end

        if (push && push_entry.op == OP_HLT) halted_d = 1'b1;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CW'(push) - CW'(pop);
        if (mem_rd) fetch_pc_d = fetch_pc_q + 16'd1;

        // A redirect overrides everything decided above in this cycle.
        if (branch_valid) begin
            st_d       = ST_OP;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            halted_d   = 1'b0;
            fetch_pc_d = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
            st_q       <= ST_OP;
            op_q       <= '0;
            b2_q       <= '0;
            len_q      <= '0;
            pc_q       <= '0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
            st_q       <= st_d;
            op_q       <= op_d;
            b2_q       <= b2_d;
            len_q      <= len_d;
            pc_q       <= pc_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_8085.sv
// Bench for instr_fetch_8085: single-instruction vector table, directed
// multi-cycle sequences, then random ROM/branch/ready traffic against a model.
module tb_instr_fetch_8085;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_b2;
    logic [7:0]  instr_b3;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  rom [0:65535];
    logic [41:0] exp_q [$];

    instr_fetch_8085 #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_b2      (instr_b2),
        .instr_b3      (instr_b3),
        .instr_len     (instr_len),
        .instr_pc      (instr_pc)
    );

    // ---------------- clock / ROM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [41:0] mk(input logic [7:0] op, input logic [7:0] b2,
                                       input logic [7:0] b3, input logic [1:0] len,
                                       input logic [15:0] pc);
        return {op, b2, b3, len, pc};
    endfunction

    function automatic logic [41:0] head_now();
        return {instr_opcode, instr_b2, instr_b3, instr_len, instr_pc};
    endfunction

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD,
                       8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
                       8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC})
            return 2'd3;
        if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                       8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                       8'hD3, 8'hDB})
            return 2'd2;
        return 2'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) tick();
    endtask

    task automatic rom_fill(input logic [7:0] v);
        for (int i = 0; i < 65536; i++) rom[i] = v;
    endtask

    // Expected instruction stream from an address: decode until the first HLT.
    task automatic parse_from(input logic [15:0] start);
        logic [15:0] a;
        logic [7:0]  op, b2, b3;
        logic [1:0]  l;
        exp_q.delete();
        a = start;
        for (int n = 0; n < 200; n++) begin
            op = rom[a];
            l  = ref_len(op);
            b2 = (l >= 2'd2) ? rom[16'(a + 16'd1)] : 8'h00;
            b3 = (l == 2'd3) ? rom[16'(a + 16'd2)] : 8'h00;
            exp_q.push_back(mk(op, b2, b3, l, a));
            if (op == 8'h76) break;
            a = a + 16'(l);
        end
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        instr_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_fields", head_now(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // ---------------- single-instruction vector table ----------------
    typedef struct {
        logic [7:0] b0, b1, b2;
        int         vcyc;
        logic [1:0] len;
        logic [7:0] eb2, eb3;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          reads, pops;
        logic [15:0] exp_pc;
        logic        br;
        int          since;

        vecs[0]  = '{8'h00, 8'hAA, 8'hBB, 2, 2'd1, 8'h00, 8'h00};
        vecs[1]  = '{8'h3E, 8'h42, 8'hBB, 3, 2'd2, 8'h42, 8'h00};
        vecs[2]  = '{8'hC3, 8'h34, 8'h12, 4, 2'd3, 8'h34, 8'h12};
        vecs[3]  = '{8'hCD, 8'h78, 8'h56, 4, 2'd3, 8'h78, 8'h56};
        vecs[4]  = '{8'hDA, 8'h11, 8'h22, 4, 2'd3, 8'h11, 8'h22};
        vecs[5]  = '{8'hF4, 8'h33, 8'h44, 4, 2'd3, 8'h33, 8'h44};
        vecs[6]  = '{8'hDB, 8'h99, 8'h55, 3, 2'd2, 8'h99, 8'h00};
        vecs[7]  = '{8'h2A, 8'h10, 8'h20, 4, 2'd3, 8'h10, 8'h20};
        vecs[8]  = '{8'h31, 8'hAB, 8'hCD, 4, 2'd3, 8'hAB, 8'hCD};
        vecs[9]  = '{8'hFE, 8'h07, 8'h66, 3, 2'd2, 8'h07, 8'h00};
        vecs[10] = '{8'h76, 8'h12, 8'h34, 2, 2'd1, 8'h00, 8'h00};
        vecs[11] = '{8'hC9, 8'h12, 8'h34, 2, 2'd1, 8'h00, 8'h00};
        vecs[12] = '{8'h7F, 8'h3E, 8'h34, 2, 2'd1, 8'h00, 8'h00};

        for (int v = 0; v < 13; v++) begin
            rom_fill(8'h00);
            rom[0] = vecs[v].b0;
            rom[1] = vecs[v].b1;
            rom[2] = vecs[v].b2;
            reset_dut();
            at_cycle(vecs[v].vcyc - 1);
            #2;
            chk("vec_not_early", instr_valid, 0);
            tick();
            #2;
            chk("vec_valid", instr_valid, 1);
            chk("vec_head", head_now(), mk(vecs[v].b0, vecs[v].eb2, vecs[v].eb3, vecs[v].len, 16'h0000));
        end

        // ---- MVI A,42h ; HLT with ready high ----
        rom_fill(8'h00);
        rom[0] = 8'h3E; rom[1] = 8'h42; rom[2] = 8'h76; rom[3] = 8'hC3;
        reset_dut();
        instr_ready = 1'b1;
        #2;
        chk("first_issue", {mem_rd, mem_addr}, {1'b1, RESET_PC});
        at_cycle(2);
        #2;
        chk("mvi_not_early", instr_valid, 0);
        tick(); #2;
        chk("mvi_valid", instr_valid, 1);
        chk("mvi_head", head_now(), mk(8'h3E, 8'h42, 8'h00, 2'd2, 16'h0000));
        tick(); #2;
        chk("hlt_valid", instr_valid, 1);
        chk("hlt_head", head_now(), mk(8'h76, 8'h00, 8'h00, 2'd1, 16'h0002));
        for (int i = 0; i < 6; i++) begin
            tick(); #2;
            chk("halt_no_read", mem_rd, 0);
            chk("halt_no_instr", instr_valid, 0);
        end

        // ---- NOP stream: back-pressure then sustained drain ----
        rom_fill(8'h00);
        reset_dut();
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (mem_rd) reads++;
            if (c == 9) chk("nop_hold_head", head_now(), mk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0000));
            tick();
        end
        chk("nop_reads", reads, DEPTH);
        instr_ready = 1'b1;
        exp_pc = 16'h0000;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (instr_valid) begin
                chk("nop_order", head_now(), mk(8'h00, 8'h00, 8'h00, 2'd1, exp_pc));
                exp_pc++;
                pops++;
            end
            tick();
        end
        chk("nop_throughput", pops, 20);

        // ---- branch while waiting for byte 3 of a JMP ----
        rom_fill(8'h00);
        rom[0] = 8'hC3; rom[1] = 8'h34; rom[2] = 8'h12;
        rom[16'h0100] = 8'h76; rom[16'h0101] = 8'hC3;
        reset_dut();
        instr_ready = 1'b1;
        at_cycle(3);
        branch_valid  = 1'b1;
        branch_target = 16'h0100;
        #2;
        chk("br_no_read", mem_rd, 0);
        tick();
        branch_valid = 1'b0;
        #2;
        chk("br_target_read", {mem_rd, mem_addr}, {1'b1, 16'h0100});
        chk("br_dropped_b4", instr_valid, 0);
        tick(); #2;
        chk("br_dropped_b5", instr_valid, 0);
        tick(); #2;
        chk("br_target_valid", instr_valid, 1);
        chk("br_target_head", head_now(), mk(8'h76, 8'h00, 8'h00, 2'd1, 16'h0100));

        // ---- branch and pop together with a full FIFO ----
        rom_fill(8'h00);
        rom[16'h0200] = 8'h76; rom[16'h0201] = 8'hC3;
        reset_dut();
        at_cycle(3);
        #2;
        chk("full_head", head_now(), mk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0000));
        chk("full_no_read", mem_rd, 0);
        tick();
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 16'h0200;
        tick();
        branch_valid = 1'b0;
        #2;
        chk("flush_empty5", instr_valid, 0);
        tick(); #2;
        chk("flush_empty6", instr_valid, 0);
        tick(); #2;
        chk("flush_target", head_now(), mk(8'h76, 8'h00, 8'h00, 2'd1, 16'h0200));

        // ---- asynchronous reset in the middle of a JMP ----
        rom_fill(8'h00);
        rom[4] = 8'hC3; rom[5] = 8'h34; rom[6] = 8'h12;
        reset_dut();
        instr_ready = 1'b1;
        at_cycle(5);
        #2;
        chk("mid_addr", {mem_rd, mem_addr}, {1'b1, 16'h0005});
        chk("mid_head", {instr_valid, head_now()}, {1'b1, mk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0003)});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_rd", mem_rd, 0);
        reset_dut();
        instr_ready = 1'b1;
        #2;
        chk("restart_addr", {mem_rd, mem_addr}, {1'b1, RESET_PC});
        at_cycle(2);
        #2;
        chk("restart_head", {instr_valid, head_now()}, {1'b1, mk(8'h00, 8'h00, 8'h00, 2'd1, RESET_PC)});

        // ---- random ROM, ready and branches against the stream model ----
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 400; i++) rom[$urandom_range(0, 65535)] = 8'h76;
        // A byte fetched just after HLT may be captured; make it the start of
        // a 3-byte opcode so it can never complete into an instruction.
        for (int i = 0; i < 65536; i++) begin
            if (rom[i] == 8'h76) rom[(i + 1) % 65536] = 8'hC3;
        end
        reset_dut();
        parse_from(RESET_PC);
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            br = (since >= 40) || ($urandom_range(0, 29) == 0);
            branch_valid  = br;
            branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                        : 16'($urandom);
            instr_ready   = ($urandom_range(0, 3) != 0);
            #2;
            if (br) begin
                parse_from(branch_target);
                since = 0;
            end else begin
                since++;
                if (instr_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rand_extra: got instr at pc %h want none", instr_pc);
                    end else begin
                        chk("rand_head", head_now(), exp_q[0]);
                        if (instr_ready) void'(exp_q.pop_front());
                    end
                end
            end
            tick();
        end
        branch_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
